// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: RV32I memory-stage controller.
// Turns EX/MEM load/store control into a registered, held-until-response
// data-cache request. Stalls the pipeline while the request is outstanding.
// Produces the aligned, sign/zero-extended load result for MEM/WB.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [3:0]  dmem_mbe,
  output logic [31:0] dmem_wdata,
  output logic [31:0] mem_data_out,
  output logic        stall,
  output logic        access_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic        dmem_read_q, dmem_read_d;
  logic        dmem_write_q, dmem_write_d;
  logic [31:0] dmem_address_q, dmem_address_d;
  logic [3:0]  dmem_mbe_q, dmem_mbe_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [31:0] mem_data_out_q, mem_data_out_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;

  logic [1:0]  off;
  logic        is_mem_op;
  logic        aligned;
  logic        f3_legal;
  logic        legal;
  logic [3:0]  req_mbe;
  logic [31:0] req_wdata;
  logic [31:0] load_shifted;
  logic [31:0] load_result;

  assign off       = addr[1:0];
  assign is_mem_op = mem_read | mem_write;

  // Legality of the incoming access: size alignment plus funct3 encodings (mem_read wins over mem_write)
  always_comb begin
    aligned  = 1'b1;
    f3_legal = 1'b0;
    case (funct3[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    if (mem_read) begin
      f3_legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
    end else begin
      f3_legal = (funct3[2] == 1'b0) && (funct3[1:0] != 2'b11);
    end
    legal = f3_legal & aligned;
  end

  // Byte enables and lane-shifted write data for the request being accepted
  always_comb begin
    req_mbe   = 4'b1111;
    req_wdata = 32'h0;
    if (!mem_read) begin
      case (funct3[1:0])
        2'b00: begin
          req_mbe   = 4'b0001 << off;
          req_wdata = store_data << {off, 3'b000};
        end
        2'b01: begin
          req_mbe   = 4'b0011 << off;
          req_wdata = store_data << {off, 3'b000};
        end
        default: begin
          req_mbe   = 4'b1111;
          req_wdata = store_data;
        end
      endcase
    end
  end

  // Align the returned word using the latched offset, then extend by the latched access type
  always_comb begin
    load_shifted = dmem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_result = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b100:  load_result = {24'h0, load_shifted[7:0]};
      3'b001:  load_result = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b101:  load_result = {16'h0, load_shifted[15:0]};
      default: load_result = load_shifted;
    endcase
  end

  // Next-state and output logic: accept in IDLE, hold in ACCESS until resp, release in DONE
  always_comb begin
    state_d        = state_q;
    dmem_read_d    = dmem_read_q;
    dmem_write_d   = dmem_write_q;
    dmem_address_d = dmem_address_q;
    dmem_mbe_d     = dmem_mbe_q;
    dmem_wdata_d   = dmem_wdata_q;
    mem_data_out_d = mem_data_out_q;
    funct3_d       = funct3_q;
    off_d          = off_q;
    stall          = 1'b0;
    access_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && is_mem_op) begin
          if (legal) begin
            funct3_d       = funct3;
            off_d          = off;
            dmem_address_d = {addr[31:2], 2'b00};
            dmem_mbe_d     = req_mbe;
            dmem_wdata_d   = req_wdata;
            dmem_read_d    = mem_read;
            dmem_write_d   = mem_write & ~mem_read;
            state_d        = ACCESS;
            stall          = 1'b1;
          end else begin
            access_err = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (dmem_resp) begin
          if (dmem_read_q) begin
            mem_data_out_d = load_result;
          end
          dmem_read_d  = 1'b0;
          dmem_write_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dmem_read_q    <= 1'b0;
      dmem_write_q   <= 1'b0;
      dmem_address_q <= 32'h0;
      dmem_mbe_q     <= 4'h0;
      dmem_wdata_q   <= 32'h0;
      mem_data_out_q <= 32'h0;
      funct3_q       <= 3'b000;
      off_q          <= 2'b00;
    end else begin
      state_q        <= state_d;
      dmem_read_q    <= dmem_read_d;
      dmem_write_q   <= dmem_write_d;
      dmem_address_q <= dmem_address_d;
      dmem_mbe_q     <= dmem_mbe_d;
      dmem_wdata_q   <= dmem_wdata_d;
      mem_data_out_q <= mem_data_out_d;
      funct3_q       <= funct3_d;
      off_q          <= off_d;
    end
  end

  assign dmem_read    = dmem_read_q;
  assign dmem_write   = dmem_write_q;
  assign dmem_address = dmem_address_q;
  assign dmem_mbe     = dmem_mbe_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign mem_data_out = mem_data_out_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed plus randomized checks of mem_stage_ctrl
// against a byte-level behavioural model of RV32I loads and stores.
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic [31:0] mem_data_out;
  logic        stall;
  logic        access_err;

  int          vectors;
  int          miscompares;
  logic [31:0] last_load;

  mem_stage_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_mbe     (dmem_mbe),
    .dmem_wdata   (dmem_wdata),
    .mem_data_out (mem_data_out),
    .stall        (stall),
    .access_err   (access_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Access width in bytes implied by funct3
  function automatic int accessBytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  // Whether an access is legal: allowed encoding and naturally aligned
  function automatic bit modelLegal(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
    bit enc_ok;
    if (is_load) enc_ok = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    else         enc_ok = (f3 == 0) || (f3 == 1) || (f3 == 2);
    return enc_ok && ((a % accessBytes(f3)) == 0);
  endfunction

  // Byte enables: every byte the access touches, counted from the byte offset
  function automatic logic [3:0] modelMbe(input bit is_load, input logic [2:0] f3, input logic [31:0] a);
    int m;
    if (is_load) return 4'hF;
    m = ((1 << accessBytes(f3)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  // Write data moved onto the byte lanes selected by the address
  function automatic logic [31:0] modelWdata(input logic [31:0] sd, input logic [31:0] a);
    logic [63:0] v;
    v = {32'h0, sd} << (8 * (a % 4));
    return v[31:0];
  endfunction

  // Load value: pick bytes starting at the offset, then extend per signedness
  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int nbits;
    logic [63:0] r;
    nbits = 8 * accessBytes(f3);
    v = longint'({32'h0, rd}) >> (8 * (a % 4));
    v = v % (longint'(1) << nbits);
    if (!f3[2] && nbits < 32 && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    r = v;
    return r[31:0];
  endfunction

  // One comparison: counted, and reported with tag/observed/expected when wrong
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one EX/MEM instruction and follow it through to completion, checking every cycle
  task automatic applyStimulus(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] sd, input logic [31:0] rdat, input int delay, input string tag);
    bit is_load;
    bit is_store;
    bit ok;
    is_load  = rd;
    is_store = wr & ~rd;
    @(negedge clk);
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    dmem_rdata = rdat;
    dmem_resp  = 1'b0;
    #1;
    checkOutput({tag, "/t_rd"}, 32'(dmem_read), 32'(0));
    checkOutput({tag, "/t_wr"}, 32'(dmem_write), 32'(0));
    checkOutput({tag, "/t_data"}, mem_data_out, last_load);
    if (!(rd || wr)) begin
      checkOutput({tag, "/nop_stall"}, 32'(stall), 32'(0));
      checkOutput({tag, "/nop_err"}, 32'(access_err), 32'(0));
      return;
    end
    ok = modelLegal(is_load, f3, a);
    if (!ok) begin
      checkOutput({tag, "/bad_err"}, 32'(access_err), 32'(1));
      checkOutput({tag, "/bad_stall"}, 32'(stall), 32'(0));
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      checkOutput({tag, "/bad_rd"}, 32'(dmem_read), 32'(0));
      checkOutput({tag, "/bad_wr"}, 32'(dmem_write), 32'(0));
      checkOutput({tag, "/bad_err2"}, 32'(access_err), 32'(0));
      checkOutput({tag, "/bad_data"}, mem_data_out, last_load);
      return;
    end
    checkOutput({tag, "/acc_stall"}, 32'(stall), 32'(1));
    checkOutput({tag, "/acc_err"}, 32'(access_err), 32'(0));
    for (int c = 0; c <= delay; c++) begin
      @(negedge clk);
      dmem_resp = (c == delay);
      #1;
      checkOutput({tag, "/rd"}, 32'(dmem_read), 32'(is_load));
      checkOutput({tag, "/wr"}, 32'(dmem_write), 32'(is_store));
      checkOutput({tag, "/address"}, dmem_address, {a[31:2], 2'b00});
      checkOutput({tag, "/mbe"}, 32'(dmem_mbe), 32'(modelMbe(is_load, f3, a)));
      if (is_store) checkOutput({tag, "/wdata"}, dmem_wdata, modelWdata(sd, a));
      checkOutput({tag, "/stall"}, 32'(stall), 32'(1));
      checkOutput({tag, "/hold_data"}, mem_data_out, last_load);
    end
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    if (is_load) last_load = modelLoad(f3, a, rdat);
    checkOutput({tag, "/done_stall"}, 32'(stall), 32'(0));
    checkOutput({tag, "/done_rd"}, 32'(dmem_read), 32'(0));
    checkOutput({tag, "/done_wr"}, 32'(dmem_write), 32'(0));
    checkOutput({tag, "/done_data"}, mem_data_out, last_load);
  endtask

  // Directed scenarios followed by a randomized sweep
  initial begin
    int kind;
    clk         = 1'b0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    funct3      = 3'b000;
    addr        = 32'h0;
    store_data  = 32'h0;
    dmem_rdata  = 32'h0;
    dmem_resp   = 1'b0;
    vectors     = 0;
    miscompares = 0;
    last_load   = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst/rd", 32'(dmem_read), 32'(0));
    checkOutput("rst/wr", 32'(dmem_write), 32'(0));
    checkOutput("rst/address", dmem_address, 32'h0);
    checkOutput("rst/mbe", 32'(dmem_mbe), 32'h0);
    checkOutput("rst/wdata", dmem_wdata, 32'h0);
    checkOutput("rst/data", mem_data_out, 32'h0);
    checkOutput("rst/stall", 32'(stall), 32'(0));
    checkOutput("rst/err", 32'(access_err), 32'(0));
    rst = 1'b0;

    applyStimulus(1, 0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3, "lw1004");
    checkOutput("lw1004/const", mem_data_out, 32'hDEAD_BEEF);
    applyStimulus(1, 0, 3'b000, 32'h0000_2003, 32'h0, 32'h80AA_BBCC, 1, "lb2003");
    checkOutput("lb2003/const", mem_data_out, 32'hFFFF_FF80);
    applyStimulus(1, 0, 3'b100, 32'h0000_2003, 32'h0, 32'h80AA_BBCC, 0, "lbu2003");
    checkOutput("lbu2003/const", mem_data_out, 32'h0000_0080);
    applyStimulus(1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'h8001_0000, 2, "lhu2002");
    checkOutput("lhu2002/const", mem_data_out, 32'h0000_8001);
    applyStimulus(0, 1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 1, "sh3002");
    applyStimulus(0, 1, 3'b000, 32'h0000_3001, 32'h0000_0055, 32'h0, 0, "sb3001");
    applyStimulus(1, 0, 3'b010, 32'h0000_4001, 32'h0, 32'h0, 0, "lw_mis");
    applyStimulus(0, 1, 3'b001, 32'h0000_4003, 32'h0, 32'h0, 0, "sh_mis");
    applyStimulus(1, 0, 3'b111, 32'h0000_4000, 32'h0, 32'h0, 0, "ld_rsv");
    applyStimulus(0, 1, 3'b100, 32'h0000_4000, 32'h0, 32'h0, 0, "st_rsv");
    applyStimulus(1, 1, 3'b001, 32'h0000_5002, 32'h0, 32'hC3A5_0000, 0, "rdwr");

    // Response pulse while idle must not disturb anything
    @(negedge clk);
    req_valid = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 32'h1111_2222;
    #1;
    checkOutput("idle_resp/stall", 32'(stall), 32'(0));
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    checkOutput("idle_resp/rd", 32'(dmem_read), 32'(0));
    checkOutput("idle_resp/data", mem_data_out, last_load);

    // Reset two cycles into ACCESS, then a late response
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    funct3    = 3'b010;
    addr      = 32'h0000_6000;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_mid/pre_rd", 32'(dmem_read), 32'(1));
    rst       = 1'b1;
    mem_read  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_load = 32'h0;
    #1;
    checkOutput("rst_mid/rd", 32'(dmem_read), 32'(0));
    checkOutput("rst_mid/stall", 32'(stall), 32'(0));
    checkOutput("rst_mid/data", mem_data_out, 32'h0);
    @(negedge clk);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hFACE_CAFE;
    #1;
    checkOutput("late_resp/stall", 32'(stall), 32'(0));
    @(negedge clk);
    dmem_resp = 1'b0;
    #1;
    checkOutput("late_resp/rd", 32'(dmem_read), 32'(0));
    checkOutput("late_resp/wr", 32'(dmem_write), 32'(0));
    checkOutput("late_resp/data", mem_data_out, 32'h0);
    applyStimulus(1, 0, 3'b010, 32'h0000_6004, 32'h0, 32'h0BAD_F00D, 1, "lw_after_rst");

    // Back-to-back LW then SW, immediate response each
    applyStimulus(1, 0, 3'b010, 32'h0000_7000, 32'h0, 32'h1357_9BDF, 0, "b2b_lw");
    applyStimulus(0, 1, 3'b010, 32'h0000_7004, 32'hA5A5_5A5A, 32'h0, 0, "b2b_sw");

    // Randomized sweep over op type, funct3, address, data and latency
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 3);
      applyStimulus(kind == 0 || kind == 2, kind == 1 || kind == 2, 3'($urandom_range(0, 7)),
                    $urandom, $urandom, $urandom, $urandom_range(0, 4), $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    req_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
